pipereg_skid: RTL and testbench
===============================

Name: pipereg_skid

Overview:
- Parametrised successor to the single-lane stall/flush pipeline register.
- Carries a bundle of LANES micro-ops between pipeline stages using a valid/ready handshake.
- A 2-slot skid buffer gives full throughput with a registered in_ready.
- Flush is selective by ROB age: only lanes strictly younger than the redirecting instruction are squashed. The stage can therefore sit between rename, issue and execute without stalling on redirect.

Parameters:
- LANES, 2, number of micro-op lanes per bundle.
- DATA_W, 128, payload bits per lane (decoded control, pc, results; opaque to this block).
- ROBID_W, 7, ROB id width; MSB is the wrap flag, low ROBID_W-1 bits are the index.

Ports:
- clock  in  1  single clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  LANES  per-lane valid of incoming bundle.
- in_ready  out  1  bundle accepted when any in_valid & in_ready.
- in_data  in  LANES*DATA_W  lane i at [i*DATA_W +: DATA_W].
- in_robid  in  LANES*ROBID_W  ROB id per lane.
- out_valid  out  LANES  per-lane valid of head bundle.
- out_ready  in  1  consumer accepts head bundle.
- out_data  out  LANES*DATA_W  head payload.
- out_robid  out  LANES*ROBID_W  head ROB ids.
- redirect_flush  in  1  redirect pulse.
- redirect_robid  in  ROBID_W  ROB id of redirecting instruction.
- occupancy  out  2  number of non-empty slots (0..2).

Behaviour:
- Storage:
  - main slot (drives out_*) and skid slot, each holding LANES x {valid, data, robid}.
  - A slot is occupied iff any of its lane valids is set.
- State: EMPTY (0 slots), ONE (main only), TWO (main + skid); occupancy encodes it.
- Handshake:
  - in_fire = |in_valid & in_ready.
  - out_fire = |out_valid & out_ready.
  - in_ready = ~skid occupied; it is a registered value with no combinational path from out_ready.
- Transitions, no flush:
  - EMPTY + in_fire -> ONE; bundle lands in main. Latency 1 cycle.
  - ONE + in_fire + out_fire -> ONE; new bundle replaces main.
  - ONE + in_fire, no out_fire -> TWO; bundle lands in skid.
  - ONE + out_fire only -> EMPTY.
  - TWO + out_fire -> ONE; skid moves to main. in_fire is impossible in TWO.
  - Otherwise hold; payload stable while out_valid & ~out_ready.
- Age compare, younger(a, r):
  - (a.wrap != r.wrap) XOR (a.idx > r.idx).
  - Equal ids are not younger; the redirecting op itself survives.
- Flush cycle (redirect_flush = 1):
  - Occurs regardless of out_ready.
  - out_fire in the same cycle is honoured: the consumer took the head bundle before the flush applies.
  - Every remaining lane (main, skid, and incoming lanes if in_fire) with younger(robid, redirect_robid) has its valid cleared at the clock edge.
  - Surviving lanes keep their lane position. There is no compaction.
  - After filtering, slots are re-packed: if main is empty and skid is non-empty, skid moves to main. An incoming bundle with no surviving lanes is dropped. State and occupancy are recomputed from the remaining slots.
- Data/robid of invalidated lanes are don't-care.
  - The bench checks only valid lanes.
  - The implementation zeroes payload only on reset.
- Reset (asserted at any time, including mid-transfer):
  - out_valid=0, out_data=0, out_robid=0, skid cleared, occupancy=0.
  - in_ready=1 while reset is asserted and after release.
- No X propagation:
  - in_data is never sampled when in_ready=0.
  - Flush compare is ignored for lanes whose valid is 0.

Test Plan:
- Streaming: out_ready=1; drive 8 back-to-back bundles with robid 0,1 / 2,3 / ...
  - out matches each input 1 cycle later.
  - in_ready stays 1; occupancy stays 1.
- Backpressure: out_ready=0 for 3 cycles during streaming.
  - 2nd bundle lands in skid; in_ready drops to 0 the cycle after; occupancy=2.
  - Release out_ready: bundles drain in order with no loss or duplication.
- Partial flush: main robids {5,6}, skid {7,8}; redirect_robid=6.
  - Next cycle: main valid=2'b11, lane1 still id 6. Skid cleared, occupancy=1.
- Wrap-around flush: main robids {0x3E, 0x41} (0x41 has wrap=1, idx 1); redirect_robid=0x3F.
  - Lane1 (0x41) flushed; lane0 (0x3E) kept.
- Full flush with same-cycle traffic: state TWO, out_ready=1, redirect_robid older than all held lanes.
  - Head bundle is consumed in that cycle; skid is squashed.
  - Next cycle: out_valid=0, occupancy=0, in_ready=1.
- Async reset mid-stall: assert reset between clock edges in state TWO.
  - out_valid=0 and occupancy=0 immediately, without waiting for a clock edge.
  - After release, a new bundle appears 1 cycle after in_fire.

Source files
------------

// File: rtl/pipereg_skid.sv
// Purpose: LANES-wide valid/ready pipeline register with 2-slot skid buffer and age-selective flush.
// Latency: 1 cycle from in_fire to out_valid; full throughput while out_ready stays high.
// Backpressure: in_ready comes from skid occupancy state only, with no combinational path from out_ready.
module pipereg_skid #(
    parameter int LANES   = 2,
    parameter int DATA_W  = 128,
    parameter int ROBID_W = 7
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [LANES-1:0]           in_valid,
    output logic                       in_ready,
    input  logic [LANES*DATA_W-1:0]    in_data,
    input  logic [LANES*ROBID_W-1:0]   in_robid,
    output logic [LANES-1:0]           out_valid,
    input  logic                       out_ready,
    output logic [LANES*DATA_W-1:0]    out_data,
    output logic [LANES*ROBID_W-1:0]   out_robid,
    input  logic                       redirect_flush,
    input  logic [ROBID_W-1:0]         redirect_robid,
    output logic [1:0]                 occupancy
);

    // Main slot drives the outputs; skid slot catches one bundle while main stalls.
    logic [LANES-1:0]         m_vld, s_vld;
    logic [LANES*DATA_W-1:0]  m_dat, s_dat;
    logic [LANES*ROBID_W-1:0] m_rob, s_rob;

    logic m_occ, s_occ, in_fire, out_fire;

    // Remaining lanes after consumption and flush: a = main, b = skid, c = incoming.
    logic [LANES-1:0] a_vld, b_vld, c_vld;
    logic a_occ, b_occ, c_occ;

    // Wrap-aware age compare: true when a was allocated after r.
    function automatic logic younger(input logic [ROBID_W-1:0] a, input logic [ROBID_W-1:0] r);
        return (a[ROBID_W-1] != r[ROBID_W-1]) ^ (a[ROBID_W-2:0] > r[ROBID_W-2:0]);
    endfunction

    assign m_occ     = |m_vld;
    assign s_occ     = |s_vld;
    assign in_ready  = ~s_occ;
    assign in_fire   = (|in_valid) & in_ready;
    assign out_fire  = m_occ & out_ready;
    assign out_valid = m_vld;
    assign out_data  = m_dat;
    assign out_robid = m_rob;
    assign occupancy = s_occ ? 2'd2 : (m_occ ? 2'd1 : 2'd0);

    // Filter every surviving lane against the redirect; invalid lanes stay 0 regardless of robid.
    always_comb begin
        a_vld = out_fire ? '0 : m_vld;
        b_vld = s_vld;
        c_vld = in_fire ? in_valid : '0;
        for (int i = 0; i < LANES; i++) begin
            a_vld[i] = a_vld[i] & ~(redirect_flush & younger(m_rob[i*ROBID_W +: ROBID_W], redirect_robid));
            b_vld[i] = b_vld[i] & ~(redirect_flush & younger(s_rob[i*ROBID_W +: ROBID_W], redirect_robid));
            c_vld[i] = c_vld[i] & ~(redirect_flush & younger(in_robid[i*ROBID_W +: ROBID_W], redirect_robid));
        end
        a_occ = |a_vld;
        b_occ = |b_vld;
        c_occ = |c_vld;
    end

    // Re-pack oldest-first (main, skid, incoming) into main then skid; payload only moves on a load.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            m_vld <= '0;
            m_dat <= '0;
            m_rob <= '0;
            s_vld <= '0;
            s_dat <= '0;
            s_rob <= '0;
        end else begin
            if (a_occ) begin
                m_vld <= a_vld;
                if (b_occ) begin
                    s_vld <= b_vld;
                end else if (c_occ) begin
                    s_vld <= c_vld;
                    s_dat <= in_data;
                    s_rob <= in_robid;
                end else begin
                    s_vld <= '0;
                end
            end else if (b_occ) begin
                m_vld <= b_vld;
                m_dat <= s_dat;
                m_rob <= s_rob;
                if (c_occ) begin
                    s_vld <= c_vld;
                    s_dat <= in_data;
                    s_rob <= in_robid;
                end else begin
                    s_vld <= '0;
                end
            end else if (c_occ) begin
                m_vld <= c_vld;
                m_dat <= in_data;
                m_rob <= in_robid;
                s_vld <= '0;
            end else begin
                m_vld <= '0;
                s_vld <= '0;
            end
        end
    end

endmodule

// File: tb/tb_pipereg_skid.sv
module tb_pipereg_skid;

    localparam int LANES   = 2;
    localparam int DATA_W  = 128;
    localparam int ROBID_W = 7;

    logic                      clock;
    logic                      reset;
    logic [LANES-1:0]          in_valid;
    logic                      in_ready;
    logic [LANES*DATA_W-1:0]   in_data;
    logic [LANES*ROBID_W-1:0]  in_robid;
    logic [LANES-1:0]          out_valid;
    logic                      out_ready;
    logic [LANES*DATA_W-1:0]   out_data;
    logic [LANES*ROBID_W-1:0]  out_robid;
    logic                      redirect_flush;
    logic [ROBID_W-1:0]        redirect_robid;
    logic [1:0]                occupancy;

    int vectors;
    int miscompares;

    pipereg_skid #(.LANES(LANES), .DATA_W(DATA_W), .ROBID_W(ROBID_W)) dut (
        .clock          (clock),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_data        (in_data),
        .in_robid       (in_robid),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .out_robid      (out_robid),
        .redirect_flush (redirect_flush),
        .redirect_robid (redirect_robid),
        .occupancy      (occupancy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Payload derived from the robid so each lane carries a recognisable pattern.
    function automatic logic [DATA_W-1:0] mk(input logic [ROBID_W-1:0] r);
        return {4{8'hC3, 17'h0, r}};
    endfunction

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input logic [1:0] vld, input logic [6:0] r0, input logic [6:0] r1);
        in_valid = vld;
        in_robid = {r1, r0};
        in_data  = {mk(r1), mk(r0)};
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_head(input string tag, input logic [6:0] r0, input logic [6:0] r1);
        chk({tag, "_vld"}, 256'(out_valid), 256'(2'b11));
        chk({tag, "_rob"}, 256'(out_robid), 256'({r1, r0}));
        chk({tag, "_dat"}, 256'(out_data), 256'({mk(r1), mk(r0)}));
    endtask

    initial begin
        vectors        = 0;
        miscompares    = 0;
        reset          = 1'b1;
        out_ready      = 1'b0;
        redirect_flush = 1'b0;
        redirect_robid = '0;
        set_in(2'b00, 7'd0, 7'd0);

        // Reset state
        #12;
        chk("rst_out_valid", 256'(out_valid), 256'(0));
        chk("rst_occ", 256'(occupancy), 256'(0));
        chk("rst_in_ready", 256'(in_ready), 256'(1));
        chk("rst_out_data", 256'(out_data), 256'(0));
        chk("rst_out_robid", 256'(out_robid), 256'(0));
        reset = 1'b0;
        tick();

        // Streaming: 8 back-to-back bundles, each visible one cycle after acceptance
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            set_in(2'b11, 7'(2*k), 7'(2*k+1));
            tick();
            chk_head("stream", 7'(2*k), 7'(2*k+1));
            chk("stream_in_ready", 256'(in_ready), 256'(1));
            chk("stream_occ", 256'(occupancy), 256'(1));
        end
        set_in(2'b00, 7'd0, 7'd0);
        tick();
        chk("stream_drain_occ", 256'(occupancy), 256'(0));
        chk("stream_drain_vld", 256'(out_valid), 256'(0));

        // Backpressure: stall 3 cycles, second bundle goes to skid
        out_ready = 1'b0;
        set_in(2'b11, 7'd20, 7'd21);
        tick();
        chk_head("bp_first", 7'd20, 7'd21);
        chk("bp_first_occ", 256'(occupancy), 256'(1));
        chk("bp_first_rdy", 256'(in_ready), 256'(1));
        set_in(2'b11, 7'd22, 7'd23);
        tick();
        chk("bp_skid_occ", 256'(occupancy), 256'(2));
        chk("bp_skid_rdy", 256'(in_ready), 256'(0));
        chk_head("bp_hold1", 7'd20, 7'd21);
        set_in(2'b11, 7'd24, 7'd25);
        tick();
        chk("bp_hold_occ", 256'(occupancy), 256'(2));
        chk_head("bp_hold2", 7'd20, 7'd21);
        out_ready = 1'b1;
        tick();
        chk_head("bp_drain1", 7'd22, 7'd23);
        chk("bp_drain1_occ", 256'(occupancy), 256'(1));
        chk("bp_drain1_rdy", 256'(in_ready), 256'(1));
        tick();
        chk_head("bp_drain2", 7'd24, 7'd25);
        set_in(2'b00, 7'd0, 7'd0);
        tick();
        chk("bp_empty_occ", 256'(occupancy), 256'(0));

        // Partial flush: main {5,6}, skid {7,8}, redirect 6
        out_ready = 1'b0;
        set_in(2'b11, 7'd5, 7'd6);
        tick();
        set_in(2'b11, 7'd7, 7'd8);
        tick();
        chk("pf_pre_occ", 256'(occupancy), 256'(2));
        set_in(2'b00, 7'd0, 7'd0);
        redirect_flush = 1'b1;
        redirect_robid = 7'd6;
        tick();
        redirect_flush = 1'b0;
        chk_head("pf_main", 7'd5, 7'd6);
        chk("pf_occ", 256'(occupancy), 256'(1));
        chk("pf_rdy", 256'(in_ready), 256'(1));
        out_ready = 1'b1;
        tick();
        chk("pf_drain_occ", 256'(occupancy), 256'(0));

        // Wrap-around flush: main {0x3E, 0x41}, redirect 0x3F
        out_ready = 1'b0;
        set_in(2'b11, 7'h3E, 7'h41);
        tick();
        set_in(2'b00, 7'd0, 7'd0);
        redirect_flush = 1'b1;
        redirect_robid = 7'h3F;
        tick();
        redirect_flush = 1'b0;
        chk("wrap_vld", 256'(out_valid), 256'(2'b01));
        chk("wrap_rob0", 256'(out_robid[6:0]), 256'(7'h3E));
        chk("wrap_dat0", 256'(out_data[DATA_W-1:0]), 256'(mk(7'h3E)));
        chk("wrap_occ", 256'(occupancy), 256'(1));
        out_ready = 1'b1;
        tick();
        chk("wrap_drain_occ", 256'(occupancy), 256'(0));

        // Incoming bundle filtered on the way in; fully squashed bundle is dropped
        out_ready = 1'b0;
        set_in(2'b11, 7'd10, 7'd12);
        redirect_flush = 1'b1;
        redirect_robid = 7'd11;
        tick();
        chk("inflush_vld", 256'(out_valid), 256'(2'b01));
        chk("inflush_rob0", 256'(out_robid[6:0]), 256'(7'd10));
        out_ready = 1'b1;
        set_in(2'b11, 7'd12, 7'd13);
        tick();
        redirect_flush = 1'b0;
        set_in(2'b00, 7'd0, 7'd0);
        chk("indrop_vld", 256'(out_valid), 256'(0));
        chk("indrop_occ", 256'(occupancy), 256'(0));

        // Full flush with same-cycle consumption from state TWO
        out_ready = 1'b0;
        set_in(2'b11, 7'd30, 7'd31);
        tick();
        set_in(2'b11, 7'd32, 7'd33);
        tick();
        chk("ff_pre_occ", 256'(occupancy), 256'(2));
        set_in(2'b00, 7'd0, 7'd0);
        out_ready      = 1'b1;
        redirect_flush = 1'b1;
        redirect_robid = 7'd29;
        chk_head("ff_head_taken", 7'd30, 7'd31);
        tick();
        redirect_flush = 1'b0;
        chk("ff_vld", 256'(out_valid), 256'(0));
        chk("ff_occ", 256'(occupancy), 256'(0));
        chk("ff_rdy", 256'(in_ready), 256'(1));

        // Asynchronous reset mid-stall in state TWO
        out_ready = 1'b0;
        set_in(2'b11, 7'd40, 7'd41);
        tick();
        set_in(2'b11, 7'd42, 7'd43);
        tick();
        chk("ar_pre_occ", 256'(occupancy), 256'(2));
        set_in(2'b00, 7'd0, 7'd0);
        #3;
        reset = 1'b1;
        #1;
        chk("ar_vld", 256'(out_valid), 256'(0));
        chk("ar_occ", 256'(occupancy), 256'(0));
        chk("ar_rdy", 256'(in_ready), 256'(1));
        chk("ar_rob", 256'(out_robid), 256'(0));
        #2;
        reset = 1'b0;
        out_ready = 1'b1;
        set_in(2'b11, 7'd50, 7'd51);
        tick();
        chk_head("ar_after", 7'd50, 7'd51);
        chk("ar_after_occ", 256'(occupancy), 256'(1));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
